// File: rtl/bank_sc_pkg.sv
// Shared opcodes, line-state encoding and FSM state codes for the per-bank SRAM controller.
package bank_sc_pkg;
  localparam logic [2:0] OP_WRITE    = 3'd0;
  localparam logic [2:0] OP_READ     = 3'd1;
  localparam logic [2:0] OP_LINEFILL = 3'd2;
  localparam logic [2:0] OP_WBACK    = 3'd3;

  localparam logic [1:0] STATE_DIRTY = 2'b11;

  typedef logic [3:0] sc_state_t;
  localparam sc_state_t S_IDLE    = 4'd0;
  localparam sc_state_t S_WB_RDB  = 4'd1;
  localparam sc_state_t S_SRAM_WR = 4'd2;
  localparam sc_state_t S_SRAM_RD = 4'd3;
  localparam sc_state_t S_RD_RESP = 4'd4;
  localparam sc_state_t S_LF_WR0  = 4'd5;
  localparam sc_state_t S_LF_WR1  = 4'd6;
  localparam sc_state_t S_EV_RD0  = 4'd7;
  localparam sc_state_t S_EV_RD1  = 4'd8;
  localparam sc_state_t S_EV_CAP  = 4'd9;
  localparam sc_state_t S_EV_SEND = 4'd10;
endpackage

// File: rtl/bank_sram_ctrl_if.sv
// Issue-queue to SRAM-controller op handshake (iq_sc_*).
interface bank_sram_ctrl_if #(
  parameter int SW_WIDTH = 6,
  parameter int BEAT_W   = 128,
  parameter int WBID_W   = 8
);
  logic                iq_sc_valid_i;
  logic                iq_sc_ready_o;
  logic [1:0]          iq_sc_channel_id_i;
  logic [2:0]          iq_sc_opcode_i;
  logic [SW_WIDTH:0]   iq_sc_set_way_offset_i;
  logic [WBID_W-1:0]   iq_sc_wbuffer_id_i;
  logic [2:0]          iq_sc_xbar_rob_num_i;
  logic [1:0]          iq_sc_cacheline_state_offset0_i;
  logic [1:0]          iq_sc_cacheline_state_offset1_i;
  logic [BEAT_W-1:0]   iq_sc_linefill_data_offset0_i;
  logic [BEAT_W-1:0]   iq_sc_linefill_data_offset1_i;

  modport master (
    output iq_sc_valid_i, iq_sc_channel_id_i, iq_sc_opcode_i, iq_sc_set_way_offset_i,
           iq_sc_wbuffer_id_i, iq_sc_xbar_rob_num_i, iq_sc_cacheline_state_offset0_i,
           iq_sc_cacheline_state_offset1_i, iq_sc_linefill_data_offset0_i,
           iq_sc_linefill_data_offset1_i,
    input  iq_sc_ready_o
  );
  modport slave (
    input  iq_sc_valid_i, iq_sc_channel_id_i, iq_sc_opcode_i, iq_sc_set_way_offset_i,
           iq_sc_wbuffer_id_i, iq_sc_xbar_rob_num_i, iq_sc_cacheline_state_offset0_i,
           iq_sc_cacheline_state_offset1_i, iq_sc_linefill_data_offset0_i,
           iq_sc_linefill_data_offset1_i,
    output iq_sc_ready_o
  );
endinterface

// File: rtl/bank_sc_evict_buf.sv
// Eviction line buffer: captures the two SRAM beats and holds them on the BIU write port until accepted.
module bank_sc_evict_buf #(
  parameter int BEAT_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cap0_i,
  input  logic              cap1_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              send_i,
  input  logic              wready_i,
  output logic              wvalid_o,
  output logic [2*BEAT_W-1:0] wdata_o,
  output logic              done_o
);
  logic [2*BEAT_W-1:0] line_d, line_q;

  always_comb begin
    line_d = line_q;
    if (cap0_i) line_d[BEAT_W-1:0]        = beat_i;
    if (cap1_i) line_d[2*BEAT_W-1:BEAT_W] = beat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) line_q <= '0;
    else       line_q <= line_d;
  end

  // Line is frozen while send_i is high, so wdata stays stable through backpressure.
  assign wvalid_o = send_i;
  assign wdata_o  = send_i ? line_q : '0;
  assign done_o   = send_i & wready_i;
endmodule

// File: rtl/bank_sram_ctrl.sv
// Per-bank SRAM controller: sequences write/read/linefill/writeback ops over a single-port SRAM.
// Optional macro BANK_SC_PERF_CNT_EN adds per-opcode saturating accept counters on sc_perf_cnt_o.
module bank_sram_ctrl
  import bank_sc_pkg::*;
#(
  parameter int SW_WIDTH = 6,
  parameter int BEAT_W   = 128,
  parameter int WBID_W   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  bank_sram_ctrl_if.slave       iq,
  output logic                  sc_wbuffer_ren_o,
  output logic [WBID_W-1:0]     sc_wbuffer_raddr_o,
  input  logic [BEAT_W-1:0]     wbuffer_sc_rdata_i,
  output logic                  sram_cen_o,
  output logic                  sram_wen_o,
  output logic [SW_WIDTH:0]     sram_addr_o,
  output logic [BEAT_W-1:0]     sram_wdata_o,
  input  logic [BEAT_W-1:0]     sram_rdata_i,
  output logic                  sc_resp_valid_o,
  output logic [1:0]            sc_resp_ch_id_o,
  output logic [2:0]            sc_resp_rob_num_o,
  output logic                  sc_resp_is_write_o,
  output logic [BEAT_W-1:0]     sc_resp_data_o,
  output logic                  sc_biu_wvalid_o,
  input  logic                  biu_sc_wready_i,
  output logic [SW_WIDTH-1:0]   sc_biu_waddr_o,
  output logic [2*BEAT_W-1:0]   sc_biu_wdata_o
`ifdef BANK_SC_PERF_CNT_EN
  ,
  output logic [127:0]          sc_perf_cnt_o
`endif
);
  typedef struct packed {
    logic [1:0]        ch;
    logic [2:0]        rob;
    logic [SW_WIDTH:0] swo;
    logic [WBID_W-1:0] wbid;
    logic [BEAT_W-1:0] ld0;
    logic [BEAT_W-1:0] ld1;
  } lat_t;

  sc_state_t state_d, state_q;
  lat_t      lat_d, lat_q;
  logic      accept, dirty, ev_done;
  logic [SW_WIDTH-1:0] sw;

  assign accept          = iq.iq_sc_valid_i & (state_q == S_IDLE);
  assign iq.iq_sc_ready_o = (state_q == S_IDLE);
  assign dirty = (iq.iq_sc_cacheline_state_offset0_i == STATE_DIRTY) |
                 (iq.iq_sc_cacheline_state_offset1_i == STATE_DIRTY);
  assign sw    = lat_q.swo[SW_WIDTH:1];

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: if (accept) begin
        lat_d = '{ch: iq.iq_sc_channel_id_i, rob: iq.iq_sc_xbar_rob_num_i,
                  swo: iq.iq_sc_set_way_offset_i, wbid: iq.iq_sc_wbuffer_id_i,
                  ld0: iq.iq_sc_linefill_data_offset0_i, ld1: iq.iq_sc_linefill_data_offset1_i};
        case (iq.iq_sc_opcode_i)
          OP_WRITE:    state_d = S_WB_RDB;
          OP_READ:     state_d = S_SRAM_RD;
          OP_LINEFILL: state_d = S_LF_WR0;
          OP_WBACK:    state_d = dirty ? S_EV_RD0 : S_IDLE;
          default:     state_d = S_IDLE;
        endcase
      end
      S_WB_RDB:  state_d = S_SRAM_WR;
      S_SRAM_RD: state_d = S_RD_RESP;
      S_LF_WR0:  state_d = S_LF_WR1;
      S_EV_RD0:  state_d = S_EV_RD1;
      S_EV_RD1:  state_d = S_EV_CAP;
      S_EV_CAP:  state_d = S_EV_SEND;
      S_EV_SEND: if (ev_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    sc_wbuffer_ren_o   = 1'b0;
    sc_wbuffer_raddr_o = '0;
    sram_cen_o         = 1'b0;
    sram_wen_o         = 1'b0;
    sram_addr_o        = '0;
    sram_wdata_o       = '0;
    sc_resp_valid_o    = 1'b0;
    sc_resp_is_write_o = 1'b0;
    sc_resp_data_o     = '0;
    case (state_q)
      S_WB_RDB: begin
        sc_wbuffer_ren_o   = 1'b1;
        sc_wbuffer_raddr_o = lat_q.wbid;
      end
      S_SRAM_WR: begin
        sram_cen_o = 1'b1; sram_wen_o = 1'b1;
        sram_addr_o  = lat_q.swo;
        sram_wdata_o = wbuffer_sc_rdata_i;
        sc_resp_valid_o = 1'b1; sc_resp_is_write_o = 1'b1;
      end
      S_SRAM_RD: begin
        sram_cen_o  = 1'b1;
        sram_addr_o = lat_q.swo;
      end
      S_RD_RESP: begin
        sc_resp_valid_o = 1'b1;
        sc_resp_data_o  = sram_rdata_i;
      end
      S_LF_WR0: begin
        sram_cen_o = 1'b1; sram_wen_o = 1'b1;
        sram_addr_o  = {sw, 1'b0};
        sram_wdata_o = lat_q.ld0;
      end
      S_LF_WR1: begin
        sram_cen_o = 1'b1; sram_wen_o = 1'b1;
        sram_addr_o  = {sw, 1'b1};
        sram_wdata_o = lat_q.ld1;
        sc_resp_valid_o = 1'b1;
        sc_resp_data_o  = lat_q.swo[0] ? lat_q.ld1 : lat_q.ld0;
      end
      S_EV_RD0: begin
        sram_cen_o  = 1'b1;
        sram_addr_o = {sw, 1'b0};
      end
      S_EV_RD1: begin
        sram_cen_o  = 1'b1;
        sram_addr_o = {sw, 1'b1};
      end
      default: ;
    endcase
  end

  assign sc_resp_ch_id_o   = sc_resp_valid_o ? lat_q.ch  : '0;
  assign sc_resp_rob_num_o = sc_resp_valid_o ? lat_q.rob : '0;
  assign sc_biu_waddr_o    = sc_biu_wvalid_o ? sw : '0;

  bank_sc_evict_buf #(.BEAT_W(BEAT_W)) u_evict_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cap0_i   (state_q == S_EV_RD1),
    .cap1_i   (state_q == S_EV_CAP),
    .beat_i   (sram_rdata_i),
    .send_i   (state_q == S_EV_SEND),
    .wready_i (biu_sc_wready_i),
    .wvalid_o (sc_biu_wvalid_o),
    .wdata_o  (sc_biu_wdata_o),
    .done_o   (ev_done)
  );

`ifdef BANK_SC_PERF_CNT_EN
  logic [3:0][31:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++)
      if (accept && iq.iq_sc_opcode_i == 3'(i) && cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sc_perf_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_bank_sram_ctrl.sv
// Directed bench for bank_sram_ctrl: scoreboard queues for channel responses and BIU evictions.
module tb_bank_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_sram_ctrl_if iqif ();

  logic         wb_ren;
  logic [7:0]   wb_raddr;
  logic [127:0] wb_rdata;
  logic         cen, wen;
  logic [6:0]   addr;
  logic [127:0] wdata, rdata;
  logic         rvalid, r_is_write;
  logic [1:0]   r_ch;
  logic [2:0]   r_rob;
  logic [127:0] r_data;
  logic         wvalid, wready;
  logic [5:0]   waddr;
  logic [255:0] wline;
`ifdef BANK_SC_PERF_CNT_EN
  logic [127:0] perf;
`endif

  bank_sram_ctrl dut (
    .clk_i(clk), .rst_i(rst), .iq(iqif),
    .sc_wbuffer_ren_o(wb_ren), .sc_wbuffer_raddr_o(wb_raddr), .wbuffer_sc_rdata_i(wb_rdata),
    .sram_cen_o(cen), .sram_wen_o(wen), .sram_addr_o(addr), .sram_wdata_o(wdata),
    .sram_rdata_i(rdata),
    .sc_resp_valid_o(rvalid), .sc_resp_ch_id_o(r_ch), .sc_resp_rob_num_o(r_rob),
    .sc_resp_is_write_o(r_is_write), .sc_resp_data_o(r_data),
    .sc_biu_wvalid_o(wvalid), .biu_sc_wready_i(wready), .sc_biu_waddr_o(waddr),
    .sc_biu_wdata_o(wline)
`ifdef BANK_SC_PERF_CNT_EN
    , .sc_perf_cnt_o(perf)
`endif
  );

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};

  // SRAM and write-buffer models, 1-cycle read latency; unwritten SRAM words return fixed preload values
  logic [127:0] mem [128];
  logic         mem_wr [128];
  always @(posedge clk) begin
    if (cen && wen) begin
      mem[addr]    <= wdata;
      mem_wr[addr] <= 1'b1;
    end
    if (cen && !wen) begin
      if (mem_wr[addr] === 1'b1) rdata <= mem[addr];
      else case (addr)
        7'h10:   rdata <= 128'hDEAD;
        7'h3E:   rdata <= 128'hA;
        7'h3F:   rdata <= 128'hB;
        default: rdata <= '0;
      endcase
    end
    wb_rdata <= (wb_ren && wb_raddr == 8'h11) ? PAT_A5 : '0;
  end

  typedef struct { logic [1:0] ch; logic [2:0] rob; logic w; logic [127:0] d; } resp_t;
  typedef struct { logic [5:0] a; logic [255:0] d; } biu_t;
  resp_t rq[$];
  biu_t  bq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (rq.size() == 0) chk("unexpected_resp", 1'b1, 1'b0);
      else begin
        resp_t e;
        e = rq.pop_front();
        chk("resp_ch", r_ch, e.ch);
        chk("resp_rob", r_rob, e.rob);
        chk("resp_is_write", r_is_write, e.w);
        if (!e.w) chk("resp_data", r_data, e.d);
      end
    end
  end

  // BIU monitor
  always @(negedge clk) begin
    if (!rst && wvalid && wready) begin
      if (bq.size() == 0) chk("unexpected_biu", 1'b1, 1'b0);
      else begin
        biu_t e;
        e = bq.pop_front();
        chk("biu_waddr", waddr, e.a);
        chk("biu_wdata", wline, e.d);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [2:0] rob,
                       input logic [6:0] swo, input logic [7:0] wbid,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic [127:0] d0, input logic [127:0] d1);
    @(posedge clk); #1;
    iqif.iq_sc_valid_i = 1'b1;
    iqif.iq_sc_opcode_i = op;
    iqif.iq_sc_channel_id_i = ch;
    iqif.iq_sc_xbar_rob_num_i = rob;
    iqif.iq_sc_set_way_offset_i = swo;
    iqif.iq_sc_wbuffer_id_i = wbid;
    iqif.iq_sc_cacheline_state_offset0_i = s0;
    iqif.iq_sc_cacheline_state_offset1_i = s1;
    iqif.iq_sc_linefill_data_offset0_i = d0;
    iqif.iq_sc_linefill_data_offset1_i = d1;
    @(posedge clk); #1;
    iqif.iq_sc_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wready = 1'b0;
    rdata = '0;
    iqif.iq_sc_valid_i = 1'b0;
    iqif.iq_sc_opcode_i = '0;
    iqif.iq_sc_channel_id_i = '0;
    iqif.iq_sc_xbar_rob_num_i = '0;
    iqif.iq_sc_set_way_offset_i = '0;
    iqif.iq_sc_wbuffer_id_i = '0;
    iqif.iq_sc_cacheline_state_offset0_i = '0;
    iqif.iq_sc_cacheline_state_offset1_i = '0;
    iqif.iq_sc_linefill_data_offset0_i = '0;
    iqif.iq_sc_linefill_data_offset1_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", iqif.iq_sc_ready_o, 1'b1);
    chk("reset_cen", cen, 1'b0);
    chk("reset_ren", wb_ren, 1'b0);
    chk("reset_resp_valid", rvalid, 1'b0);
    chk("reset_wvalid", wvalid, 1'b0);

    // Write: wbuffer 0x11 -> SRAM 0x2B
    rq.push_back('{ch: 2'd2, rob: 3'd5, w: 1'b1, d: '0});
    issue(3'd0, 2'd2, 3'd5, 7'h2B, 8'h11, 2'b00, 2'b00, '0, '0);
    @(negedge clk);
    chk("wr_t1_ren", wb_ren, 1'b1);
    chk("wr_t1_raddr", wb_raddr, 8'h11);
    chk("wr_t1_ready", iqif.iq_sc_ready_o, 1'b0);
    @(negedge clk);
    chk("wr_t2_cen_wen", {cen, wen}, 2'b11);
    chk("wr_t2_addr", addr, 7'h2B);
    chk("wr_t2_wdata", wdata, PAT_A5);
    chk("wr_t2_ready", iqif.iq_sc_ready_o, 1'b0);
    @(negedge clk);
    chk("wr_t3_ready", iqif.iq_sc_ready_o, 1'b1);
    chk("wr_mem", mem[7'h2B], PAT_A5);

    // Read 0x10
    rq.push_back('{ch: 2'd1, rob: 3'd3, w: 1'b0, d: 128'hDEAD});
    issue(3'd1, 2'd1, 3'd3, 7'h10, 8'h00, 2'b00, 2'b00, '0, '0);
    @(negedge clk);
    chk("rd_t1_cen_wen", {cen, wen}, 2'b10);
    chk("rd_t1_addr", addr, 7'h10);
    @(negedge clk);
    @(negedge clk);
    chk("rd_t3_ready", iqif.iq_sc_ready_o, 1'b1);

    // Linefill on set_way 2, offset 1
    rq.push_back('{ch: 2'd3, rob: 3'd7, w: 1'b0, d: 128'h2});
    issue(3'd2, 2'd3, 3'd7, 7'h05, 8'h00, 2'b00, 2'b00, 128'h1, 128'h2);
    @(negedge clk);
    chk("lf_t1_cen_wen", {cen, wen}, 2'b11);
    chk("lf_t1_addr", addr, 7'h04);
    chk("lf_t1_wdata", wdata, 128'h1);
    @(negedge clk);
    chk("lf_t2_addr", addr, 7'h05);
    chk("lf_t2_wdata", wdata, 128'h2);
    @(negedge clk);
    chk("lf_mem0", mem[7'h04], 128'h1);
    chk("lf_mem1", mem[7'h05], 128'h2);

    // Dirty writeback of set_way 0x1F with 3 cycles of BIU backpressure
    bq.push_back('{a: 6'h1F, d: {128'hB, 128'hA}});
    issue(3'd3, 2'd0, 3'd1, 7'h3E, 8'h00, 2'b11, 2'b00, '0, '0);
    @(negedge clk);
    chk("ev_t1_cen_addr", {cen, wen, addr}, {2'b10, 7'h3E});
    @(negedge clk);
    chk("ev_t2_cen_addr", {cen, wen, addr}, {2'b10, 7'h3F});
    @(negedge clk);
    chk("ev_t3_cen", cen, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ev_hold_wvalid", wvalid, 1'b1);
      chk("ev_hold_waddr", waddr, 6'h1F);
      chk("ev_hold_wdata", wline, {128'hB, 128'hA});
      chk("ev_hold_ready", iqif.iq_sc_ready_o, 1'b0);
    end
    @(posedge clk); #1 wready = 1'b1;
    @(posedge clk); #1 wready = 1'b0;
    @(negedge clk);
    chk("ev_idle_ready", iqif.iq_sc_ready_o, 1'b1);
    chk("ev_idle_wvalid", wvalid, 1'b0);

    // Clean writeback: nothing happens
    issue(3'd3, 2'd0, 3'd2, 7'h20, 8'h00, 2'b00, 2'b01, '0, '0);
    @(negedge clk);
    chk("clean_ready", iqif.iq_sc_ready_o, 1'b1);
    chk("clean_cen", cen, 1'b0);
    chk("clean_wvalid", wvalid, 1'b0);

    // Reserved opcode
    issue(3'd5, 2'd1, 3'd1, 7'h11, 8'h11, 2'b11, 2'b11, '0, '0);
    @(negedge clk);
    chk("rsvd_ready", iqif.iq_sc_ready_o, 1'b1);
    chk("rsvd_side_effects", {cen, wb_ren, rvalid, wvalid}, 4'b0);

    // Reset mid-read drops the op
    issue(3'd1, 2'd2, 3'd4, 7'h10, 8'h00, 2'b00, 2'b00, '0, '0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_ready", iqif.iq_sc_ready_o, 1'b1);
      chk("rst_mid_no_resp", rvalid, 1'b0);
    end

`ifdef BANK_SC_PERF_CNT_EN
    issue(3'd1, 2'd0, 3'd0, 7'h10, 8'h00, 2'b00, 2'b00, '0, '0);
    rq.push_back('{ch: 2'd0, rob: 3'd0, w: 1'b0, d: 128'hDEAD});
    repeat (3) @(negedge clk);
    chk("perf_cnt", perf, {32'd0, 32'd0, 32'd1, 32'd0});
`endif

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("biu_queue_drained", 32'(bq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
